// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Arbitrates a single-ported RAM between an instruction cache (read only)
//   and a data cache (word-wise block fill / write-back).
//
//   - The data cache is normally preferred.
//   - A saturating starvation counter forces an instruction grant after
//     STARVE_MAX consecutive data completions that happened while the
//     icache was waiting.
//   - Each grant lasts until the RAM reports ACCESS, which completes the
//     transfer in that same cycle.
//   - An ERROR from the RAM costs one RETRY cycle with all strobes low.
//     The same grant is then reissued.
//
// Ports:
//   CLK       in   1   system clock, rising edge
//   nRST      in   1   asynchronous active-low reset
//   iREN      in   1   icache read request
//   iaddr     in   32  icache word address
//   iwait     out  1   icache stall, low only on its completion cycle
//   iload     out  32  instruction data (ramload passthrough)
//   dREN      in   1   dcache read request (one word per transaction)
//   dWEN      in   1   dcache write request (one word per transaction)
//   daddr     in   32  dcache word address
//   dstore    in   32  dcache write data
//   dwait     out  1   dcache stall, low only on its completion cycle
//   dload     out  32  read data to dcache (ramload passthrough)
//   ramREN    out  1   RAM read strobe
//   ramWEN    out  1   RAM write strobe
//   ramaddr   out  32  RAM word-aligned address
//   ramstore  out  32  RAM write data
//   ramload   in   32  RAM read data
//   ramstate  in   2   0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
//
// Parameters:
//   STARVE_MAX  number of consecutive data grants allowed before the icache
//               is forced through (default 4)
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  // icache side
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  // dcache side
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  // RAM side
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  // ---------------------------------------------------------------------------
  // Encodings
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2,
    RETRY  = 2'd3
  } state_t;

  localparam logic [1:0] RAM_FREE   = 2'd0;
  localparam logic [1:0] RAM_BUSY   = 2'd1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  // Widened copy of the limit so the counter compare has matching widths.
  localparam logic [31:0] STARVE_LIMIT = 32'(STARVE_MAX);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t     state_reg;
  state_t     state_next;

  // Which grant a RETRY returns to (1 = data side, 0 = instruction side).
  logic       retry_dside_reg;
  logic       retry_dside_next;

  logic [2:0] starve_cnt_reg;
  logic [2:0] starve_cnt_next;

  // ---------------------------------------------------------------------------
  // Decoded helpers
  // ---------------------------------------------------------------------------
  logic d_req;
  logic d_done;
  logic i_done;
  logic d_preferred;
  logic ram_access;
  logic ram_error;

  // Low two address bits are discarded because RAM is word addressed.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{daddr[1:0], iaddr[1:0]};

  assign d_req       = dREN | dWEN;
  assign ram_access  = (ramstate == RAM_ACCESS);
  assign ram_error   = (ramstate == RAM_ERROR);
  assign d_preferred = ({29'd0, starve_cnt_reg} < STARVE_LIMIT);

  // A completion needs the request still present; a request dropped in the
  // same cycle ACCESS arrives is treated as abandoned, not completed.
  assign d_done = (state_reg == DGRANT) && d_req && ram_access;
  assign i_done = (state_reg == IGRANT) && iREN  && ram_access;

  // ---------------------------------------------------------------------------
  // Process 1: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg       <= IDLE;
      retry_dside_reg <= 1'b0;
      starve_cnt_reg  <= 3'd0;
    end else begin
      state_reg       <= state_next;
      retry_dside_reg <= retry_dside_next;
      starve_cnt_reg  <= starve_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Process 2: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next       = state_reg;
    retry_dside_next = retry_dside_reg;

    unique case (state_reg)
      IDLE: begin
        if (d_req && d_preferred) begin
          state_next = DGRANT;
        end else if (iREN) begin
          state_next = IGRANT;
        end else if (d_req) begin
          state_next = DGRANT;
        end else begin
          state_next = IDLE;
        end
      end

      DGRANT: begin
        if (!d_req) begin
          state_next = IDLE;
        end else if (ram_access) begin
          state_next = IDLE;
        end else if (ram_error) begin
          state_next       = RETRY;
          retry_dside_next = 1'b1;
        end else begin
          state_next = DGRANT;
        end
      end

      IGRANT: begin
        if (!iREN) begin
          state_next = IDLE;
        end else if (ram_access) begin
          state_next = IDLE;
        end else if (ram_error) begin
          state_next       = RETRY;
          retry_dside_next = 1'b0;
        end else begin
          state_next = IGRANT;
        end
      end

      RETRY: begin
        // Always one cycle long. If the requestor has gone away by then,
        // the reissued grant sees the dropped request and falls back to IDLE.
        state_next = retry_dside_reg ? DGRANT : IGRANT;
      end

      default: state_next = IDLE;
    endcase
  end

  // Starvation counter:
  //   - cleared whenever the icache is not asking, or when it is served;
  //   - incremented (saturating) on each data completion it had to wait behind.
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (!iREN || i_done) begin
      starve_cnt_next = 3'd0;
    end else if (d_done && (starve_cnt_reg != 3'd7)) begin
      starve_cnt_next = starve_cnt_reg + 3'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Process 3: output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'd0;
    ramstore = 32'd0;
    iwait    = 1'b1;
    dwait    = 1'b1;

    unique case (state_reg)
      DGRANT: begin
        // A simultaneous read and write request is served as a write only.
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramaddr  = {daddr[31:2], 2'b00};
        ramstore = dstore;
        dwait    = ~d_done;
      end

      IGRANT: begin
        ramREN  = 1'b1;
        ramaddr = {iaddr[31:2], 2'b00};
        iwait   = ~i_done;
      end

      default: begin
        // IDLE and RETRY drive nothing toward the RAM.
      end
    endcase
  end

  // Read data is shared; each cache qualifies it with its own wait.
  assign iload = ramload;
  assign dload = ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed testbench for mem_arbiter with hand-computed expectations.
// Inputs change 1 ns after the rising edge, and outputs are sampled 1 ns later.
// Because the outputs are combinational from the state, each sample reflects
// the current cycle's state.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  int checks_total  = 0;
  int checks_passed = 0;

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs === exp) begin
      checks_passed++;
      $display("check %-24s ok   obs=0x%08h", tag, obs);
    end else begin
      $display("FAIL %-24s obs=0x%08h exp=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Let combinational outputs settle after input changes.
  task automatic settle();
    #1;
  endtask

  initial begin
    nRST     = 1'b0;
    iREN     = 1'b0;
    iaddr    = 32'd0;
    dREN     = 1'b0;
    dWEN     = 1'b0;
    daddr    = 32'd0;
    dstore   = 32'd0;
    ramload  = 32'd0;
    ramstate = FREE;

    // ---------------- reset state ----------------
    tick();
    settle();
    check("rst_ramREN",   {31'd0, ramREN},   32'd0);
    check("rst_ramWEN",   {31'd0, ramWEN},   32'd0);
    check("rst_ramaddr",  ramaddr,           32'd0);
    check("rst_ramstore", ramstore,          32'd0);
    check("rst_iwait",    {31'd0, iwait},    32'd1);
    check("rst_dwait",    {31'd0, dwait},    32'd1);
    nRST = 1'b1;

    // ---------------- icache read, two BUSY then ACCESS ----------------
    tick();
    iREN    = 1'b1;
    iaddr   = 32'h104;
    ramload = 32'hCAFEF00D;
    settle();
    check("i_idle_ramaddr", ramaddr, 32'd0);

    tick();  // IGRANT, first cycle
    ramstate = BUSY;
    settle();
    check("i_c1_ramaddr", ramaddr,         32'h104);
    check("i_c1_ramREN",  {31'd0, ramREN}, 32'd1);
    check("i_c1_iwait",   {31'd0, iwait},  32'd1);

    tick();  // IGRANT, second cycle
    settle();
    check("i_c2_ramaddr", ramaddr,        32'h104);
    check("i_c2_iwait",   {31'd0, iwait}, 32'd1);

    tick();  // IGRANT, third cycle completes
    ramstate = ACCESS;
    settle();
    check("i_c3_ramaddr", ramaddr,        32'h104);
    check("i_c3_iwait",   {31'd0, iwait}, 32'd0);
    check("i_c3_dwait",   {31'd0, dwait}, 32'd1);
    check("i_c3_iload",   iload,          32'hCAFEF00D);

    tick();  // back in IDLE
    iREN = 1'b0;
    settle();
    check("i_after_ramREN", {31'd0, ramREN}, 32'd0);
    check("i_after_iwait",  {31'd0, iwait},  32'd1);

    // ---------------- simultaneous iREN and dWEN: data first ----------------
    iREN   = 1'b1;
    iaddr  = 32'h104;
    dWEN   = 1'b1;
    daddr  = 32'h203;
    dstore = 32'hDEADBEEF;
    settle();

    tick();  // DGRANT completes immediately
    settle();
    check("dw_ramaddr",  ramaddr,          32'h200);
    check("dw_ramWEN",   {31'd0, ramWEN},  32'd1);
    check("dw_ramREN",   {31'd0, ramREN},  32'd0);
    check("dw_ramstore", ramstore,         32'hDEADBEEF);
    check("dw_dwait",    {31'd0, dwait},   32'd0);
    check("dw_iwait",    {31'd0, iwait},   32'd1);

    tick();  // exactly one IDLE cycle
    dWEN = 1'b0;
    settle();
    check("dw_gap_ramREN", {31'd0, ramREN}, 32'd0);
    check("dw_gap_ramWEN", {31'd0, ramWEN}, 32'd0);

    tick();  // IGRANT follows
    settle();
    check("dw_ig_ramaddr", ramaddr,         32'h104);
    check("dw_ig_ramREN",  {31'd0, ramREN}, 32'd1);
    check("dw_ig_iwait",   {31'd0, iwait},  32'd0);

    tick();  // IDLE
    iREN = 1'b0;
    settle();

    // ---------------- starvation: 4 data grants then the icache ----------------
    iREN  = 1'b1;
    iaddr = 32'h400;
    dREN  = 1'b1;
    daddr = 32'h300;
    settle();
    for (int k = 0; k < 5; k++) begin
      tick();  // grant cycle
      settle();
      if (k < 4) begin
        check($sformatf("sv_g%0d_ramaddr", k), ramaddr,        32'h300 + 32'(4 * k));
        check($sformatf("sv_g%0d_dwait", k),   {31'd0, dwait}, 32'd0);
        check($sformatf("sv_g%0d_iwait", k),   {31'd0, iwait}, 32'd1);
      end else begin
        check("sv_g4_ramaddr", ramaddr,        32'h400);
        check("sv_g4_iwait",   {31'd0, iwait}, 32'd0);
        check("sv_g4_dwait",   {31'd0, dwait}, 32'd1);
      end
      tick();  // IDLE between grants
      daddr = 32'h300 + 32'(4 * (k + 1));
      settle();
      check($sformatf("sv_idle%0d_ramREN", k), {31'd0, ramREN}, 32'd0);
    end
    iREN = 1'b0;
    dREN = 1'b0;
    settle();

    // ---------------- ERROR causes one RETRY, then the same grant ----------------
    tick();  // IDLE
    dREN     = 1'b1;
    daddr    = 32'h500;
    ramload  = 32'h12345678;
    ramstate = ERROR;
    settle();

    tick();  // DGRANT sees ERROR
    settle();
    check("er_g1_ramaddr", ramaddr,         32'h500);
    check("er_g1_ramREN",  {31'd0, ramREN}, 32'd1);
    check("er_g1_dwait",   {31'd0, dwait},  32'd1);

    tick();  // RETRY
    ramstate = BUSY;
    settle();
    check("er_rt_ramREN",  {31'd0, ramREN}, 32'd0);
    check("er_rt_ramaddr", ramaddr,         32'd0);
    check("er_rt_dwait",   {31'd0, dwait},  32'd1);

    tick();  // DGRANT reissued, still BUSY
    settle();
    check("er_g2_ramaddr", ramaddr,        32'h500);
    check("er_g2_dwait",   {31'd0, dwait}, 32'd1);

    tick();  // ACCESS completes
    ramstate = ACCESS;
    settle();
    check("er_g3_dwait", {31'd0, dwait}, 32'd0);
    check("er_g3_dload", dload,          32'h12345678);

    tick();  // IDLE
    dREN = 1'b0;
    settle();

    // ---------------- reset pulse in the middle of a DGRANT ----------------
    dREN     = 1'b1;
    dWEN     = 1'b1;
    daddr    = 32'h600;
    dstore   = 32'h0BADF00D;
    ramstate = BUSY;
    settle();

    tick();  // DGRANT with read and write together
    settle();
    check("rs_pre_ramWEN",  {31'd0, ramWEN}, 32'd1);
    check("rs_pre_ramREN",  {31'd0, ramREN}, 32'd0);
    check("rs_pre_ramaddr", ramaddr,         32'h600);

    #2;
    nRST = 1'b0;
    dREN = 1'b0;
    dWEN = 1'b0;
    settle();
    check("rs_low_ramWEN",   {31'd0, ramWEN}, 32'd0);
    check("rs_low_ramaddr",  ramaddr,         32'd0);
    check("rs_low_ramstore", ramstore,        32'd0);
    check("rs_low_dwait",    {31'd0, dwait},  32'd1);
    check("rs_low_iwait",    {31'd0, iwait},  32'd1);

    tick();
    nRST = 1'b1;
    settle();
    tick();
    settle();
    check("rs_post_ramWEN",  {31'd0, ramWEN}, 32'd0);
    check("rs_post_ramaddr", ramaddr,         32'd0);

    // ---------------- dREN dropped while BUSY ----------------
    dREN  = 1'b1;
    daddr = 32'h700;
    settle();

    tick();  // DGRANT, BUSY
    settle();
    check("dr_g1_ramREN", {31'd0, ramREN}, 32'd1);
    check("dr_g1_dwait",  {31'd0, dwait},  32'd1);

    tick();  // still BUSY, then the request is abandoned
    settle();
    check("dr_g2_dwait", {31'd0, dwait}, 32'd1);
    dREN     = 1'b0;
    ramstate = ACCESS;
    settle();
    check("dr_drop_dwait",  {31'd0, dwait},  32'd1);
    check("dr_drop_ramREN", {31'd0, ramREN}, 32'd0);

    tick();  // IDLE
    settle();
    check("dr_idle_dwait",   {31'd0, dwait}, 32'd1);
    check("dr_idle_ramaddr", ramaddr,        32'd0);

    // A fresh request is granted on the very next cycle, so the FSM was idle.
    dREN  = 1'b1;
    daddr = 32'h704;
    settle();
    tick();
    settle();
    check("dr_new_ramaddr", ramaddr,        32'h704);
    check("dr_new_dwait",   {31'd0, dwait}, 32'd0);
    dREN = 1'b0;

    tick();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
